rv_branch_resolve_unit: RTL

Parametrised successor to the combinational branch comparator in Stage_ID.
- Resolves RV32/RV64 conditional branches against a registered prediction.
- Owns a 2-bit saturating branch history table (BHT), indexed by PC, that serves next-PC prediction to IF.
- Produces a registered mispredict/redirect to the front end one cycle after resolution.

---
 rtl/rv_branch_resolve_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rv_branch_resolve_unit.sv
// rv_branch_resolve_unit
//   Resolves RV32/RV64 conditional branches against the direction IF
//   predicted, and owns the 2-bit saturating branch history table that
//   serves next-PC direction lookups back to IF.
//   Resolution and lookup each take one cycle.
//   Optional feature macro: RV_BRANCH_STATS_EN (resolved-branch and
//   mispredict counters). With the macro undefined the stat ports read 0.
module rv_branch_resolve_unit #(
  parameter int          XLEN      = 32,
  parameter int          PC_W      = 32,
  parameter int          BHT_DEPTH = 64,
  parameter logic [1:0]  BHT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_resp_valid,
  output logic            pred_resp_taken,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic [2:0]      res_branchOp,
  input  logic [XLEN-1:0] res_srcA,
  input  logic [XLEN-1:0] res_srcB,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_taken,
  output logic            out_valid,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic [PC_W-1:0] out_redirect_pc,
  output logic            out_illegal,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Elaboration-time sanity on the table geometry.
  if ((BHT_DEPTH < 4) || (BHT_DEPTH > 1024) || ((1 << IDX_W) != BHT_DEPTH)) begin : g_bad_depth
    $error("BHT_DEPTH must be a power of two in 4..1024");
  end
  if (PC_W < IDX_W + 2) begin : g_bad_pc_w
    $error("PC_W too narrow for the BHT index");
  end

  logic [1:0]       bht [BHT_DEPTH];

  logic             cmp_taken;
  logic             cmp_illegal;
  logic             res_accept;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] pred_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;
  logic [1:0]       pred_ctr;
  logic [PC_W-1:0]  redirect_pc;
  logic             mispredict;

  // Word-aligned PCs: bits [1:0] and everything above the index never
  // select an entry, so several PCs alias onto one counter by design.
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], res_pc[1:0],
                            pred_pc[PC_W-1:IDX_W+2], res_pc[PC_W-1:IDX_W+2]};

  assign upd_idx  = res_pc[IDX_W+1:2];
  assign pred_idx = pred_pc[IDX_W+1:2];

  // Branch condition evaluation, same semantics as the old ID comparator.
  always_comb begin
    cmp_taken   = 1'b0;
    cmp_illegal = 1'b0;
    case (res_branchOp)
      3'b000:  cmp_taken = (res_srcA == res_srcB);
      3'b001:  cmp_taken = (res_srcA != res_srcB);
      3'b100:  cmp_taken = ($signed(res_srcA) <  $signed(res_srcB));
      3'b101:  cmp_taken = ($signed(res_srcA) >= $signed(res_srcB));
      3'b110:  cmp_taken = (res_srcA <  res_srcB);
      3'b111:  cmp_taken = (res_srcA >= res_srcB);
      default: cmp_illegal = 1'b1;
    endcase
  end

  assign res_accept  = res_valid & ~flush;
  assign upd_en      = res_accept & ~cmp_illegal;
  assign mispredict  = cmp_taken ^ res_pred_taken;
  assign redirect_pc = cmp_taken ? res_target : (res_pc + PC_W'(4));

  // Saturating counter step for the entry being trained this cycle.
  always_comb begin
    cur_ctr = bht[upd_idx];
    nxt_ctr = cur_ctr;
    if (cmp_taken) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  // A lookup that collides with this cycle's update sees the new value.
  always_comb begin
    pred_ctr = bht[pred_idx];
    if (upd_en && (upd_idx == pred_idx)) pred_ctr = nxt_ctr;
  end

  // Branch history table: reinitialised on reset, trained by legal resolutions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_INIT;
    end else if (upd_en) begin
      bht[upd_idx] <= nxt_ctr;
    end
  end

  // Prediction response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_resp_valid <= 1'b0;
      pred_resp_taken <= 1'b0;
    end else begin
      pred_resp_valid <= pred_valid & ~flush;
      if (pred_valid && !flush) pred_resp_taken <= pred_ctr[1];
    end
  end

  // Resolution result register; payload holds when no result is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_mispredict  <= 1'b0;
      out_illegal     <= 1'b0;
      out_redirect_pc <= '0;
    end else begin
      out_valid <= res_accept;
      if (res_accept) begin
        out_taken       <= cmp_taken;
        out_mispredict  <= mispredict;
        out_illegal     <= cmp_illegal;
        out_redirect_pc <= redirect_pc;
      end
    end
  end

`ifdef RV_BRANCH_STATS_EN
  // Saturating event counters, advanced on the same edge as out_valid so
  // they always agree with the results already presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (res_accept) begin
      if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
